// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one shared signed multiplier and one accumulator step
// through all taps. A new sample is accepted only while the block is idle.
module fir_mac_seq #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coeff_we,
    input  logic [$clog2(TAPS)-1:0]    coeff_addr,
    input  logic [WIDTH-1:0]           coeff_wdata,
    output logic                       coeff_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_data,
    output logic                       busy
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = 2 * WIDTH;
    localparam logic [AW:0]   TAPS_EXT = (AW+1)'(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_reg, state_next;
    logic [AW-1:0]           idx_reg, idx_next;
    logic signed [PW-1:0]    acc_reg, acc_next;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] x_reg  [TAPS];
    logic signed [WIDTH-1:0] c_reg  [TAPS];
    logic signed [WIDTH-1:0] x_next [TAPS];
    logic [TAPS-1:0]         c_we;
    logic                    coeff_err_reg;
    logic                    accept;
    logic                    coeff_ok;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign coeff_ok = coeff_we && (state_reg == IDLE) && ({1'b0, coeff_addr} < TAPS_EXT);

    // Both operands are sign-extended to full width, so the low PW bits are the exact product.
    assign prod = PW'(x_reg[idx_reg]) * PW'(c_reg[idx_reg]);

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            assign c_we[gi] = coeff_ok && (coeff_addr == AW'(gi));
            if (gi == 0) begin : g_head
                assign x_next[gi] = in_data;
            end else begin : g_tail
                assign x_next[gi] = x_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = MAC;
                    idx_next   = '0;
                    acc_next   = '0;
                end
            end
            MAC: begin
                acc_next = acc_reg + prod;
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = OUT;
                end else begin
                    idx_next = idx_reg + AW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            acc_reg       <= '0;
            coeff_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            acc_reg       <= acc_next;
            coeff_err_reg <= coeff_we && !coeff_ok;
        end
    end

    // Coefficient writes land on the same edge as a sample handshake, so that sample sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k] <= '0;
                c_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (accept) begin
                    x_reg[k] <= x_next[k];
                end
                if (c_we[k]) begin
                    c_reg[k] <= coeff_wdata;
                end
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == OUT);
    assign out_data  = acc_reg;
    assign coeff_err = coeff_err_reg;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: a transaction-level filter model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_fir_mac_seq;

    localparam int WIDTH = 16;
    localparam int TAPS  = 8;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              coeff_we;
    logic [AW-1:0]     coeff_addr;
    logic [WIDTH-1:0]  coeff_wdata;
    logic              coeff_err;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [2*WIDTH-1:0] out_data;
    logic              busy;

    int errors = 0;
    int checks = 0;

    fir_mac_seq #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coeff_we   (coeff_we),
        .coeff_addr (coeff_addr),
        .coeff_wdata(coeff_wdata),
        .coeff_err  (coeff_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: coefficient bank, sample history, and when the
    // pending result becomes visible and is consumed.
    int           m_c [TAPS];
    int           m_x [TAPS];
    bit           m_busy;
    int           m_e;
    int           m_valid_at;
    logic [31:0]  m_y;
    bit           m_err;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                m_c[k] = 0;
                m_x[k] = 0;
            end
            m_busy = 0;
            m_err  = 0;
            m_y    = 0;
        end else begin
            bit     err_n;
            longint s;
            err_n = 0;
            m_e++;
            if (coeff_we) begin
                if (!m_busy && int'(coeff_addr) < TAPS) m_c[coeff_addr] = $signed(coeff_wdata);
                else err_n = 1;
            end
            if (!m_busy) begin
                if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
                    m_x[0] = $signed(in_data);
                    s = 0;
                    for (int k = 0; k < TAPS; k++) s += longint'(m_c[k]) * longint'(m_x[k]);
                    m_y        = s[31:0];
                    m_busy     = 1;
                    m_valid_at = m_e + TAPS;
                end
            end else if (m_e > m_valid_at && out_ready) begin
                m_busy = 0;
            end
            m_err = err_n;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_coeff_err", coeff_err, 0);
            chk("rst_out_data", out_data, 0);
        end else begin
            bit ev;
            ev = m_busy && (m_e >= m_valid_at);
            chk("in_ready", in_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, ev);
            chk("coeff_err", coeff_err, m_err);
            if (ev) chk("out_data", out_data, m_y);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wr_coeff(input int a, input int v);
        coeff_we    = 1'b1;
        coeff_addr  = a[AW-1:0];
        coeff_wdata = v[WIDTH-1:0];
        @(posedge clk); #1;
        coeff_we    = 1'b0;
    endtask

    // Lat counts cycles from the handshake cycle to the first cycle out_valid is seen.
    task automatic wait_out(output logic [31:0] y, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        y = out_data;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_sample(input int x, input bit we, input int wa, input int wv,
                              output logic [31:0] y, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = x[WIDTH-1:0];
        if (we) begin
            coeff_we    = 1'b1;
            coeff_addr  = wa[AW-1:0];
            coeff_wdata = wv[WIDTH-1:0];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coeff_we = 1'b0;
        wait_out(y, lat);
        $display("sample x=%0d -> y=%0h latency=%0d", x, y, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y;
        int          lat;
        int          imp [9];
        int          imp_exp [9];
        int          seen;

        imp     = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        imp_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

        rst_n = 1'b0; coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Impulse response
        for (int k = 0; k < TAPS; k++) wr_coeff(k, k + 1);
        for (int i = 0; i < 9; i++) begin
            run_sample(imp[i], 0, 0, 0, y, lat);
            chk($sformatf("impulse_y%0d", i), y, imp_exp[i]);
            chk($sformatf("impulse_lat%0d", i), lat, 9);
        end

        // Signed product
        do_reset();
        wr_coeff(0, -3);
        run_sample(5, 0, 0, 0, y, lat);
        chk("signed_y", y, 32'hFFFF_FFF1);

        // Backpressure: result held, inputs ignored, no shift
        do_reset();
        wr_coeff(0, 2);
        wr_coeff(1, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(y, lat);
        chk("bp_y", y, 8);
        in_valid = 1'b1;
        in_data  = 16'd77;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", out_data, 8);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            $display("backpressure cycle %0d out_data=%0h", i, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        in_valid = 1'b0;
        run_sample(6, 0, 0, 0, y, lat);
        chk("bp_no_shift_y", y, 16);

        // Coefficient write while busy is dropped
        in_valid = 1'b1;
        in_data  = 16'd3;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        coeff_we    = 1'b1;
        coeff_addr  = 3'd0;
        coeff_wdata = 16'd7;
        @(posedge clk); #1;
        coeff_we = 1'b0;
        chk("mac_wr_err", coeff_err, 1);
        @(posedge clk); #1;
        chk("mac_wr_err_clear", coeff_err, 0);
        wait_out(y, lat);
        chk("mac_wr_old_coeff_y", y, 12);
        $display("write during MAC -> y=%0h", y);

        // Coefficient write in the handshake cycle is used immediately
        run_sample(1, 1, 0, 5, y, lat);
        chk("same_cycle_wr_y", y, 8);

        // Accumulator wrap-around
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coeff(k, -32768);
        for (int i = 1; i <= 8; i++) begin
            run_sample(-32768, 0, 0, 0, y, lat);
            if (i == 1) chk("wrap_first_y", y, 32'h4000_0000);
            if (i == 8) chk("wrap_eighth_y", y, 0);
        end

        // Reset in the middle of MAC aborts the sample
        do_reset();
        wr_coeff(0, 1);
        in_valid = 1'b1;
        in_data  = 16'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        $display("abort: out_valid cycles seen=%0d", seen);
        wr_coeff(0, 1);
        run_sample(9, 0, 0, 0, y, lat);
        chk("abort_recover_y", y, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
